// File: rtl/fifo_seq_pkg.sv
// Shared types and default sizing for the FIFO-bank sequencer.
package fifo_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NUM_FIFO_DEF = 8;
  localparam int DEPTH_DEF    = 8;
  localparam int BITS_DEF     = 64;

endpackage

// File: rtl/fifo_seq_ctrl_if.sv
// Host load-word handshake between the MMIO decode (master) and the sequencer (slave).
interface fifo_seq_ctrl_if #(
  parameter int NUM_FIFO = 8,
  parameter int BITS     = 64
);
  localparam int SW = $clog2(NUM_FIFO);

  logic            load_vld;
  logic [SW-1:0]   load_sel;
  logic [BITS-1:0] load_data;
  logic            load_rdy;

  modport master (output load_vld, load_sel, load_data, input load_rdy);
  modport slave  (input load_vld, load_sel, load_data, output load_rdy);
endinterface

// File: rtl/fifo_seq_skew.sv
// Diagonal skew: column i is enabled for run cycles t in [i, i+DEPTH).
module fifo_seq_skew
  import fifo_seq_pkg::*;
#(
  parameter int  NUM_FIFO = NUM_FIFO_DEF,
  parameter int  DEPTH    = DEPTH_DEF,
  localparam int TW       = $clog2(DEPTH + NUM_FIFO)
) (
  input  logic [TW-1:0]       t,
  input  logic                active,
  output logic [NUM_FIFO-1:0] en
);
  logic [31:0] t_ext;
  assign t_ext = 32'(t);

  generate
    for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_col
      if (gi == 0) begin : g_first
        assign en[gi] = active && (t_ext < 32'(DEPTH));
      end else begin : g_rest
        assign en[gi] = active && (t_ext >= 32'(gi)) && (t_ext < 32'(gi + DEPTH));
      end
    end
  endgenerate
endmodule

// File: rtl/fifo_seq_ctrl.sv
// FILL/RUN sequencer for a bank of circular delay-buffer FIFOs feeding a MAC row.
// Define FIFO_SEQ_CYCLE_CNT_EN to add the saturating run_cycles output.
module fifo_seq_ctrl
  import fifo_seq_pkg::*;
#(
  parameter int NUM_FIFO = NUM_FIFO_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int BITS     = BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_seq_ctrl_if.slave      ld,
  input  logic                start,
  output logic [NUM_FIFO-1:0] fifo_en,
  output logic [BITS-1:0]     fifo_d,
  output logic [NUM_FIFO-1:0] col_vld,
  output logic                busy,
  output logic                done,
  output logic                err_overfill
`ifdef FIFO_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]         run_cycles
`endif
);
  localparam int SW = $clog2(NUM_FIFO);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(DEPTH + NUM_FIFO);
  localparam logic [FW-1:0] FULL   = FW'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(DEPTH + NUM_FIFO - 2);

  state_t              state_reg;
  logic [TW-1:0]       t_reg;
  logic [FW-1:0]       fill_reg [NUM_FIFO];
  logic                err_reg;
  logic [NUM_FIFO-1:0] full_vec;
  logic [NUM_FIFO-1:0] skew_en;
  logic                accept, sel_ok, sel_full, write, overfill, start_go, run_active;

  generate
    for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_full
      assign full_vec[gi] = (fill_reg[gi] == FULL);
    end
    if (NUM_FIFO == (1 << SW)) begin : g_sel_pow2
      assign sel_ok = 1'b1;
    end else begin : g_sel_range
      assign sel_ok = (32'(ld.load_sel) < 32'(NUM_FIFO));
    end
  endgenerate

  assign ld.load_rdy = (state_reg == IDLE) || (state_reg == FILL);
  assign accept      = ld.load_vld && ld.load_rdy;
  assign sel_full    = full_vec[ld.load_sel];
  assign write       = accept && sel_ok && !sel_full;
  assign overfill    = accept && (!sel_ok || sel_full);
  // start only counts against the fill levels held before this edge, so a
  // same-cycle load into an all-full bank is always an overfill.
  assign start_go    = start && (state_reg == FILL) && (&full_vec);
  assign run_active  = (state_reg == RUN);

  fifo_seq_skew #(
    .NUM_FIFO(NUM_FIFO),
    .DEPTH   (DEPTH)
  ) u_skew (
    .t     (t_reg),
    .active(run_active),
    .en    (skew_en)
  );

  always_comb begin
    fifo_en = '0;
    fifo_d  = '0;
    if (run_active) begin
      fifo_en = skew_en;
    end else if (write) begin
      fifo_en[ld.load_sel] = 1'b1;
      fifo_d               = ld.load_data;
    end
  end

  assign col_vld      = skew_en;
  assign busy         = (state_reg == FILL) || run_active;
  assign done         = (state_reg == DONE);
  assign err_overfill = err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      err_reg   <= 1'b0;
      for (int i = 0; i < NUM_FIFO; i++) fill_reg[i] <= '0;
`ifdef FIFO_SEQ_CYCLE_CNT_EN
      run_cycles <= '0;
`endif
    end else begin
      if (write) fill_reg[ld.load_sel] <= fill_reg[ld.load_sel] + 1'b1;
      if (overfill) err_reg <= 1'b1;
      case (state_reg)
        IDLE: if (accept) state_reg <= FILL;
        FILL: begin
          if (start_go) begin
            state_reg <= RUN;
            t_reg     <= '0;
            for (int i = 0; i < NUM_FIFO; i++) fill_reg[i] <= '0;
          end
        end
        RUN: begin
          if (t_reg == T_LAST) state_reg <= DONE;
          else                 t_reg     <= t_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
`ifdef FIFO_SEQ_CYCLE_CNT_EN
      if (run_active && (run_cycles != 32'hFFFF_FFFF)) run_cycles <= run_cycles + 32'd1;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Randomized bench for fifo_seq_ctrl with a queue-based reference and a behavioural FIFO bank.
module tb_fifo_seq_ctrl;
  localparam int NF = 8;
  localparam int DP = 8;
  localparam int BW = 64;
  localparam int RUN_LEN = DP + NF - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [NF-1:0] fifo_en, col_vld;
  logic [BW-1:0] fifo_d;
  logic busy, done, err_overfill;
`ifdef FIFO_SEQ_CYCLE_CNT_EN
  logic [31:0] run_cycles;
`endif

  fifo_seq_ctrl_if #(.NUM_FIFO(NF), .BITS(BW)) lif ();

  fifo_seq_ctrl #(.NUM_FIFO(NF), .DEPTH(DP), .BITS(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld          (lif),
    .start       (start),
    .fifo_en     (fifo_en),
    .fifo_d      (fifo_d),
    .col_vld     (col_vld),
    .busy        (busy),
    .done        (done),
    .err_overfill(err_overfill)
`ifdef FIFO_SEQ_CYCLE_CNT_EN
    ,
    .run_cycles  (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural circular FIFO bank sharing rst_n with the controller.
  logic [BW-1:0] hmem [NF][DP];
  int            hptr [NF];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        hptr[i] <= 0;
        for (int j = 0; j < DP; j++) hmem[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (fifo_en[i]) begin
          hmem[i][hptr[i]] <= fifo_d;
          hptr[i]          <= (hptr[i] + 1) % DP;
        end
      end
    end
  end

  // Reference model: phase 0 idle, 1 fill, 2 run, 3 done.
  int            n_checks = 0;
  int            n_fail = 0;
  int            phase;
  int            exp_fill [NF];
  bit            exp_err;
  logic [BW-1:0] exp_q [NF][$];
  int unsigned   exp_cycles;

  function automatic bit all_full();
    for (int i = 0; i < NF; i++) if (exp_fill[i] != DP) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    phase = 0;
    exp_err = 1'b0;
    exp_cycles = 0;
    for (int i = 0; i < NF; i++) begin
      exp_fill[i] = 0;
      exp_q[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    lif.load_vld = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fifo_en !== '0 || col_vld !== '0 || err_overfill !== 1'b0)
      begin n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b en=%h vld=%h err=%b required all zero", busy, done, fifo_en, col_vld, err_overfill); end
    n_checks++;
    if (lif.load_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_load_rdy: got %b required 1", lif.load_rdy); end
`ifdef FIFO_SEQ_CYCLE_CNT_EN
    n_checks++;
    if (run_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_run_cycles: got %0d required 0", run_cycles); end
`endif
    $display("reset applied");
    rst_n = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    #1;
    n_checks++;
    if (fifo_en !== '0 || col_vld !== '0 || fifo_d !== '0 || done !== 1'b0 || busy !== (phase == 1))
      begin n_fail++; $display("FAIL idle_cycle: got en=%h vld=%h d=%h done=%b busy=%b required en=0 vld=0 d=0 done=0 busy=%b", fifo_en, col_vld, fifo_d, done, busy, phase == 1); end
    n_checks++;
    if (lif.load_rdy !== (phase <= 1)) begin n_fail++; $display("FAIL idle_load_rdy: got %b required %b", lif.load_rdy, phase <= 1); end
    $display("idle cycle phase=%0d", phase);
  endtask

  task automatic do_load(input int sel, input logic [BW-1:0] data);
    logic [NF-1:0] exp_en;
    logic [BW-1:0] exp_d;
    bit acc, wr;
    @(negedge clk);
    lif.load_vld  = 1'b1;
    lif.load_sel  = 3'(sel);
    lif.load_data = data;
    #1;
    acc    = (phase <= 1);
    wr     = acc && (exp_fill[sel] < DP);
    exp_en = wr ? (NF'(1) << sel) : '0;
    exp_d  = wr ? data : '0;
    n_checks++;
    if (lif.load_rdy !== acc) begin n_fail++; $display("FAIL load_rdy: got %b required %b", lif.load_rdy, acc); end
    n_checks++;
    if (fifo_en !== exp_en) begin n_fail++; $display("FAIL load_fifo_en: sel=%0d got %h required %h", sel, fifo_en, exp_en); end
    n_checks++;
    if (fifo_d !== exp_d) begin n_fail++; $display("FAIL load_fifo_d: sel=%0d got %h required %h", sel, fifo_d, exp_d); end
    $display("load sel=%0d data=%h fill_before=%0d write=%0b", sel, data, exp_fill[sel], wr);
    @(posedge clk);
    if (acc) begin
      if (phase == 0) phase = 1;
      if (wr) begin exp_q[sel].push_back(data); exp_fill[sel]++; end
      else exp_err = 1'b1;
    end
    #1;
    lif.load_vld = 1'b0;
    n_checks++;
    if (err_overfill !== exp_err) begin n_fail++; $display("FAIL load_err_overfill: got %b required %b", err_overfill, exp_err); end
  endtask

  task automatic fill_random(input bit plan, input bit skip_last);
    int need [NF];
    int left = 0;
    for (int i = 0; i < NF; i++) begin
      need[i] = DP - exp_fill[i];
      left += need[i];
    end
    if (skip_last) begin need[NF-1]--; left--; end
    while (left > 0) begin
      int s;
      logic [BW-1:0] d;
      s = $urandom_range(NF - 1);
      if (need[s] == 0) continue;
      d = plan ? 64'(s * DP + exp_fill[s]) : {$urandom, $urandom};
      do_load(s, d);
      need[s]--;
      left--;
      if ($urandom_range(3) == 0) idle_cycle();
    end
  endtask

  task automatic do_start(input bit with_load, input int sel, input logic [BW-1:0] data);
    logic [NF-1:0] exp_en;
    bit acc, wr, taken;
    @(negedge clk);
    start = 1'b1;
    if (with_load) begin
      lif.load_vld  = 1'b1;
      lif.load_sel  = 3'(sel);
      lif.load_data = data;
    end
    #1;
    acc    = with_load && (phase <= 1);
    wr     = acc && (exp_fill[sel] < DP);
    taken  = (phase == 1) && all_full();
    exp_en = wr ? (NF'(1) << sel) : '0;
    n_checks++;
    if (fifo_en !== exp_en) begin n_fail++; $display("FAIL start_fifo_en: got %h required %h", fifo_en, exp_en); end
    $display("start with_load=%0b sel=%0d phase=%0d taken=%0b", with_load, sel, phase, taken);
    @(posedge clk);
    if (acc) begin
      if (phase == 0) phase = 1;
      if (wr) begin exp_q[sel].push_back(data); exp_fill[sel]++; end
      else exp_err = 1'b1;
    end
    if (taken) begin
      phase = 2;
      for (int i = 0; i < NF; i++) exp_fill[i] = 0;
    end
    #1;
    start = 1'b0;
    lif.load_vld = 1'b0;
    n_checks++;
    if (busy !== (phase == 1 || phase == 2)) begin n_fail++; $display("FAIL start_busy: got %b required %b", busy, phase == 1 || phase == 2); end
    n_checks++;
    if (err_overfill !== exp_err) begin n_fail++; $display("FAIL start_err_overfill: got %b required %b", err_overfill, exp_err); end
  endtask

  // Walks the RUN phase; stop_at >= 0 returns after checking that cycle.
  task automatic run_check(input int stop_at);
    logic [NF-1:0] mask;
    logic [BW-1:0] ev, gv;
    for (int c = 0; c < RUN_LEN; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NF; i++) mask[i] = (c >= i) && (c < i + DP);
      n_checks++;
      if (fifo_en !== mask) begin n_fail++; $display("FAIL run_fifo_en: t=%0d got %h required %h", c, fifo_en, mask); end
      n_checks++;
      if (col_vld !== mask) begin n_fail++; $display("FAIL run_col_vld: t=%0d got %h required %h", c, col_vld, mask); end
      n_checks++;
      if (fifo_d !== '0 || busy !== 1'b1 || done !== 1'b0 || lif.load_rdy !== 1'b0 || err_overfill !== exp_err)
        begin n_fail++; $display("FAIL run_status: t=%0d got d=%h busy=%b done=%b rdy=%b err=%b required d=0 busy=1 done=0 rdy=0 err=%b", c, fifo_d, busy, done, lif.load_rdy, err_overfill, exp_err); end
`ifdef FIFO_SEQ_CYCLE_CNT_EN
      n_checks++;
      if (run_cycles !== exp_cycles) begin n_fail++; $display("FAIL run_cycles_mid: t=%0d got %0d required %0d", c, run_cycles, exp_cycles); end
`endif
      for (int i = 0; i < NF; i++) begin
        if (mask[i]) begin
          ev = exp_q[i].pop_front();
          gv = hmem[i][hptr[i]];
          n_checks++;
          if (gv !== ev) begin n_fail++; $display("FAIL run_col_data: t=%0d col=%0d got %h required %h", c, i, gv, ev); end
        end
      end
      $display("run t=%0d fifo_en=%h", c, fifo_en);
      exp_cycles++;
      if (c == stop_at) return;
    end
    @(negedge clk);
    #1;
    phase = 3;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || lif.load_rdy !== 1'b0 || fifo_en !== '0 || col_vld !== '0 || err_overfill !== exp_err)
      begin n_fail++; $display("FAIL done_state: got done=%b busy=%b rdy=%b en=%h vld=%h err=%b required done=1 busy=0 rdy=0 en=0 vld=0 err=%b", done, busy, lif.load_rdy, fifo_en, col_vld, err_overfill, exp_err); end
`ifdef FIFO_SEQ_CYCLE_CNT_EN
    n_checks++;
    if (run_cycles !== exp_cycles) begin n_fail++; $display("FAIL run_cycles_done: got %0d required %0d", run_cycles, exp_cycles); end
`endif
    $display("done pulse");
    @(negedge clk);
    #1;
    phase = 0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lif.load_rdy !== 1'b1 || err_overfill !== exp_err)
      begin n_fail++; $display("FAIL back_to_idle: got done=%b busy=%b rdy=%b err=%b required done=0 busy=0 rdy=1 err=%b", done, busy, lif.load_rdy, err_overfill, exp_err); end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 5; k++) idle_cycle();
    do_start(1'b0, 0, '0);
    idle_cycle();
  endtask

  task automatic test_plan_run();
    fill_random(1'b1, 1'b0);
    do_start(1'b0, 0, '0);
    run_check(-1);
  endtask

  task automatic test_start_not_full();
    fill_random(1'b0, 1'b1);
    do_start(1'b0, 0, '0);
    for (int k = 0; k < 3; k++) idle_cycle();
    do_load(NF - 1, {$urandom, $urandom});
    do_start(1'b0, 0, '0);
    run_check(-1);
  endtask

  task automatic test_overfill();
    fill_random(1'b0, 1'b0);
    do_load(3, {$urandom, $urandom});
    do_start(1'b0, 0, '0);
    run_check(-1);
  endtask

  task automatic test_start_with_load();
    fill_random(1'b0, 1'b0);
    do_start(1'b1, $urandom_range(NF - 1), {$urandom, $urandom});
    run_check(-1);
  endtask

  task automatic test_mid_reset();
    fill_random(1'b0, 1'b0);
    do_start(1'b0, 0, '0);
    run_check(5);
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (fifo_en !== '0 || busy !== 1'b0 || err_overfill !== 1'b0 || lif.load_rdy !== 1'b1)
      begin n_fail++; $display("FAIL mid_reset: got en=%h busy=%b err=%b rdy=%b required en=0 busy=0 err=0 rdy=1", fifo_en, busy, err_overfill, lif.load_rdy); end
`ifdef FIFO_SEQ_CYCLE_CNT_EN
    n_checks++;
    if (run_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset_run_cycles: got %0d required 0", run_cycles); end
`endif
    $display("mid-run reset applied");
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fill_random(1'b0, 1'b0);
      do_start(1'b0, 0, '0);
      run_check(-1);
    end
`ifdef FIFO_SEQ_CYCLE_CNT_EN
    n_checks++;
    if (run_cycles !== 32'd30) begin n_fail++; $display("FAIL two_run_cycles: got %0d required 30", run_cycles); end
`endif
  endtask

  initial begin
    lif.load_vld  = 1'b0;
    lif.load_sel  = '0;
    lif.load_data = '0;
    model_reset();
    test_reset();
    test_plan_run();
    test_start_not_full();
    test_overfill();
    test_start_with_load();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_seq_ctrl.md
Name: fifo_seq_ctrl

Overview:
- Sequencer for a bank of NUM_FIFO delay-buffer FIFOs (DEPTH x BITS, circular, advance on en) that feed a systolic MAC row.
- Two phases:
  - FILL: routes host/MMIO load words into the selected FIFO and tracks fill level.
  - RUN: on start, drives diagonally skewed shift enables so FIFO i streams its DEPTH entries starting i cycles after FIFO 0.
- Sits between the MMIO register decode and the FIFO/MAC array.

Parameters:
- NUM_FIFO, 8, number of FIFOs/columns sequenced.
- DEPTH, 8, entries per FIFO; must match the FIFO instances.
- BITS, 64, data width per entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- load_vld  in  1  load word valid
- load_sel  in  $clog2(NUM_FIFO)  target FIFO index
- load_data  in  BITS  load word
- load_rdy  out  1  controller can accept a load
- start  in  1  begin streaming (single-cycle pulse expected)
- fifo_en  out  NUM_FIFO  per-FIFO shift enable
- fifo_d  out  BITS  shared data bus to all FIFO d inputs
- col_vld  out  NUM_FIFO  FIFO i output q is valid for the MAC this cycle
- busy  out  1  high in FILL or RUN
- done  out  1  one-cycle pulse at end of RUN
- err_overfill  out  1  sticky: a load targeted an already-full FIFO

Behaviour:
- Reset: synchronous, active-low, applied at clk edge while rst_n=0.
  - State = IDLE; all fill counters, the run counter and err_overfill = 0.
  - All outputs low; fifo_d = 0.
  - Mid-operation reset aborts any phase; FIFOs share rst_n, so the bank returns to all-zero consistently.
- States: IDLE, FILL, RUN, DONE.
- load_rdy:
  - Equals (state==IDLE || state==FILL).
  - Registered state only; no combinational path from inputs.
- Load accept: load_vld && load_rdy.
  - If fill[load_sel] < DEPTH: fifo_en[load_sel]=1 in the same cycle (combinational from accept), fifo_d=load_data, fill[load_sel]++.
  - If fill[load_sel]==DEPTH: word dropped, no en pulse, err_overfill set. err_overfill is cleared only by reset.
  - load_sel >= NUM_FIFO: dropped, err_overfill set.
- Transitions:
  - IDLE->FILL on first accepted load.
  - FILL->RUN when start=1 and every fill[i]==DEPTH. start is ignored otherwise (including in IDLE).
  - Same cycle start and load, all FIFOs full: start is taken and the load is treated as overfill (dropped, flag set).
  - RUN lasts exactly DEPTH+NUM_FIFO-1 cycles; run counter t = 0 .. DEPTH+NUM_FIFO-2.
  - RUN->DONE after the last RUN cycle; DONE->IDLE unconditionally after 1 cycle.
- RUN outputs:
  - fifo_en[i] = col_vld[i] = (t >= i) && (t < i+DEPTH).
  - fifo_d = 0, so the FIFOs refill with zeros.
  - The consumer samples q in the same cycle col_vld is high.
- Counters and reset of fill:
  - Each FIFO receives exactly DEPTH enables in RUN, which returns its pointer to its start position.
  - All fill counters clear to 0 on the RUN entry edge.
- DONE state: done=1, busy=0, load_rdy=0.
- Widths:
  - fill counters are $clog2(DEPTH)+1 bits.
  - run counter is $clog2(DEPTH+NUM_FIFO) bits.
  - No wrap of either counter is permitted by construction.

Optional Feature:
- Macro: FIFO_SEQ_CYCLE_CNT_EN
- Defined:
  - Adds output run_cycles [31:0], a saturating count of total RUN cycles since reset. Increments each RUN cycle and holds at 0xFFFFFFFF.
  - Readable via MMIO; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- fifo_seq_pkg:
  - state enum (IDLE, FILL, RUN, DONE) as a 2-bit typedef
  - default constants NUM_FIFO_DEF=8, DEPTH_DEF=8, BITS_DEF=64
- Sub-module fifo_seq_skew:
  - Purely combinational; maps run counter t and run-active to the NUM_FIFO-bit skewed enable vector.
  - Instantiated once; unit-testable alone.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, load_rdy=1, busy=0.
- 64 loads (sel=i, data=i*8+k), then start -> RUN 15 cycles.
  - fifo_en=8'h01 at t=0, 8'hFF at t=7, 8'h80 at t=14.
  - Column i sees values i*8+0..i*8+7 in order.
  - done pulses at cycle 16 after start.
- Start after only 63 loads (FIFO 7 has 7) -> stays FILL, no fifo_en, busy=1; 64th load then start -> RUN.
- 9th load to sel=3 -> no fifo_en pulse, err_overfill=1 and stays 1 through RUN/DONE until reset.
- rst_n=0 at RUN t=5 -> next edge: state IDLE, fifo_en=0, fill=0, err_overfill=0; a fresh fill/run passes again.
- With FIFO_SEQ_CYCLE_CNT_EN: two complete runs -> run_cycles=30.
